// File: rtl/ps2_pad_poller.sv
// rtl/ps2_pad_poller.sv - periodic PS2 gamepad poller over the SPI-like pad link
// Polls digital/analog pads, drives rumble bytes and publishes validated frames.
module ps2_pad_poller #(
  parameter int CLK_HALF    = 300,
  parameter int CS_SETUP    = 600,
  parameter int BYTE_GAP    = 600,
  parameter int POLL_PERIOD = 1000000
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        motor_small,
  input  logic [7:0]  motor_large,
  output logic [15:0] ps2_key,
  output logic [7:0]  stick_rx,
  output logic [7:0]  stick_ry,
  output logic [7:0]  stick_lx,
  output logic [7:0]  stick_ly,
  output logic [7:0]  pad_id,
  output logic        analog_mode,
  output logic        pad_present,
  output logic        data_valid,
  output logic        spi_cs,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int CMAX = (CLK_HALF > CS_SETUP) ? ((CLK_HALF > BYTE_GAP) ? CLK_HALF : BYTE_GAP)
                                              : ((CS_SETUP > BYTE_GAP) ? CS_SETUP : BYTE_GAP);
  localparam int CW = $clog2(CMAX + 1);
  localparam int PW = $clog2(POLL_PERIOD + 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_HALF - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(BYTE_GAP - 1);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_PERIOD - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP, S_DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] cyc_cnt;
  logic [PW-1:0] poll_cnt;
  logic [2:0]    bit_idx;
  logic [3:0]    byte_idx;
  logic          phase;
  logic [7:0]    rx, rx_nxt, tx_byte;
  logic          motor_small_q;
  logic [7:0]    motor_large_q;
  logic [7:0]    id_q, sync_q, key_lo, key_hi, ax_rx, ax_ry, ax_lx, ax_ly;
  logic          poll_expired, last_byte, frame_ok, is_analog;

  assign poll_expired = (poll_cnt == POLL_LAST);
  assign is_analog    = (id_q == 8'h73);
  assign last_byte    = (byte_idx == (is_analog ? 4'd8 : 4'd4));
  assign frame_ok     = (id_q == 8'h41 || is_analog) && (sync_q == 8'h5A);
  // miso is taken on the first cycle of the high phase; the bypass keeps CLK_HALF=1 correct
  assign rx_nxt       = (phase && cyc_cnt == '0) ? {spi_miso, rx[7:1]} : rx;

  always_comb begin
    tx_byte = 8'h00;
    case (byte_idx)
      4'd0:    tx_byte = 8'h01;
      4'd1:    tx_byte = 8'h42;
      4'd3:    tx_byte = motor_small_q ? 8'hFF : 8'h00;
      4'd4:    tx_byte = motor_large_q;
      default: tx_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (poll_expired && enable) state_nxt = S_SETUP;
      S_SETUP: if (cyc_cnt == SETUP_LAST) state_nxt = S_SHIFT;
      S_SHIFT: if (phase && cyc_cnt == HALF_LAST && bit_idx == 3'd7) state_nxt = S_GAP;
      S_GAP:   if (cyc_cnt == GAP_LAST) state_nxt = last_byte ? S_DONE : S_SHIFT;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    spi_cs   = 1'b1;
    spi_clk  = 1'b1;
    spi_mosi = 1'b0;
    case (state)
      S_SETUP, S_GAP: spi_cs = 1'b0;
      S_SHIFT: begin
        spi_cs   = 1'b0;
        spi_clk  = phase;
        spi_mosi = tx_byte[bit_idx];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt       <= '0;
      poll_cnt      <= '0;
      bit_idx       <= 3'd0;
      byte_idx      <= 4'd0;
      phase         <= 1'b0;
      rx            <= 8'h00;
      motor_small_q <= 1'b0;
      motor_large_q <= 8'h00;
      id_q          <= 8'h00;
      sync_q        <= 8'h00;
      key_lo        <= 8'h00;
      key_hi        <= 8'h00;
      ax_rx         <= 8'h80;
      ax_ry         <= 8'h80;
      ax_lx         <= 8'h80;
      ax_ly         <= 8'h80;
      ps2_key       <= 16'h0000;
      stick_rx      <= 8'h80;
      stick_ry      <= 8'h80;
      stick_lx      <= 8'h80;
      stick_ly      <= 8'h80;
      pad_id        <= 8'h00;
      analog_mode   <= 1'b0;
      pad_present   <= 1'b0;
      data_valid    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!poll_expired) poll_cnt <= poll_cnt + 1'b1;
          if (poll_expired && enable) begin
            poll_cnt      <= '0;
            cyc_cnt       <= '0;
            motor_small_q <= motor_small;
            motor_large_q <= motor_large;
          end
        end
        S_SETUP: begin
          if (cyc_cnt == SETUP_LAST) begin
            cyc_cnt  <= '0;
            bit_idx  <= 3'd0;
            byte_idx <= 4'd0;
            phase    <= 1'b0;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          rx <= rx_nxt;
          if (cyc_cnt == HALF_LAST) begin
            cyc_cnt <= '0;
            phase   <= ~phase;
            if (phase) begin
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == 3'd7) begin
                case (byte_idx)
                  4'd1:    id_q   <= rx_nxt;
                  4'd2:    sync_q <= rx_nxt;
                  4'd3:    key_lo <= rx_nxt;
                  4'd4:    key_hi <= rx_nxt;
                  4'd5:    ax_rx  <= rx_nxt;
                  4'd6:    ax_ry  <= rx_nxt;
                  4'd7:    ax_lx  <= rx_nxt;
                  4'd8:    ax_ly  <= rx_nxt;
                  default: ;
                endcase
              end
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cyc_cnt == GAP_LAST) begin
            cyc_cnt  <= '0;
            phase    <= 1'b0;
            byte_idx <= byte_idx + 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        S_DONE: begin
          // the chip-select-high DONE cycle is the first cycle of the poll period
          if (!poll_expired) poll_cnt <= poll_cnt + 1'b1;
          pad_id      <= id_q;
          pad_present <= frame_ok;
          data_valid  <= frame_ok;
          if (frame_ok) begin
            ps2_key     <= ~{key_hi, key_lo};
            analog_mode <= is_analog;
            stick_rx    <= is_analog ? ax_rx : 8'h80;
            stick_ry    <= is_analog ? ax_ry : 8'h80;
            stick_lx    <= is_analog ? ax_lx : 8'h80;
            stick_ly    <= is_analog ? ax_ly : 8'h80;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_pad_poller.sv
// tb/tb_ps2_pad_poller.sv - directed scoreboard bench for ps2_pad_poller
// A pad model answers each frame; published frames are checked against a queue.
module tb_ps2_pad_poller;
  localparam int CLK_HALF    = 3;
  localparam int CS_SETUP    = 5;
  localparam int BYTE_GAP    = 4;
  localparam int POLL_PERIOD = 150;
  localparam int FRAME_MAX   = 1000;

  logic        clk_50m;
  logic        rst_n, enable, motor_small, spi_miso;
  logic [7:0]  motor_large;
  logic [15:0] ps2_key;
  logic [7:0]  stick_rx, stick_ry, stick_lx, stick_ly, pad_id;
  logic        analog_mode, pad_present, data_valid, spi_cs, spi_clk, spi_mosi;

  typedef struct packed {
    logic [15:0] key;
    logic [7:0]  id;
    logic        analog;
    logic [31:0] axes;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         vectors = 0, miscompares = 0;
  int         dv_count = 0, fall_cnt = 0, mosi_unstable = 0;
  longint     cyc = 0;
  logic [7:0] resp [0:8];
  logic [7:0] mosi_byte [0:8];
  logic       mosi_b;

  ps2_pad_poller #(
    .CLK_HALF(CLK_HALF), .CS_SETUP(CS_SETUP), .BYTE_GAP(BYTE_GAP), .POLL_PERIOD(POLL_PERIOD)
  ) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .enable(enable), .motor_small(motor_small),
    .motor_large(motor_large), .ps2_key(ps2_key), .stick_rx(stick_rx), .stick_ry(stick_ry),
    .stick_lx(stick_lx), .stick_ly(stick_ly), .pad_id(pad_id), .analog_mode(analog_mode),
    .pad_present(pad_present), .data_valid(data_valid), .spi_cs(spi_cs), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  initial begin
    clk_50m = 1'b0;
    forever #10 clk_50m = ~clk_50m;
  end

  initial forever begin
    @(posedge clk_50m);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_resp(input logic [71:0] v);
    for (int i = 0; i < 9; i++) resp[i] = v[71 - 8*i -: 8];
  endtask

  task automatic push_exp(input logic [15:0] key, input logic [7:0] id, input logic analog,
                          input logic [31:0] axes);
    exp_t e;
    e.key = key; e.id = id; e.analog = analog; e.axes = axes;
    exp_q.push_back(e);
  endtask

  task automatic wait_cs(input logic lvl, input int max_cyc, input string tag);
    int n = 0;
    while (spi_cs !== lvl && n < max_cyc) begin
      @(negedge clk_50m);
      n++;
    end
    check(tag, {31'd0, spi_cs}, {31'd0, lvl});
  endtask

  // pad model: presents the next response bit on each falling spi_clk
  initial forever begin
    @(negedge spi_cs);
    fall_cnt = 0;
  end

  initial forever begin
    @(negedge spi_clk);
    if (spi_cs === 1'b0) begin
      if (fall_cnt < 72) spi_miso = resp[fall_cnt / 8][fall_cnt % 8];
      fall_cnt++;
    end
  end

  initial forever begin
    @(posedge spi_clk);
    if (spi_cs === 1'b0 && fall_cnt >= 1 && fall_cnt <= 72) begin
      mosi_byte[(fall_cnt - 1) / 8][(fall_cnt - 1) % 8] = spi_mosi;
      mosi_b = spi_mosi;
      @(posedge clk_50m);
      #1;
      if (spi_mosi !== mosi_b) mosi_unstable++;
    end
  end

  initial forever begin
    @(negedge clk_50m);
    if (data_valid === 1'b1) begin
      dv_count++;
      check("sb_expected_frame", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("sb_key", {16'd0, ps2_key}, {16'd0, mon_e.key});
        check("sb_id", {24'd0, pad_id}, {24'd0, mon_e.id});
        check("sb_analog", {31'd0, analog_mode}, {31'd0, mon_e.analog});
        check("sb_axes", {stick_rx, stick_ry, stick_lx, stick_ly}, mon_e.axes);
        check("sb_present", {31'd0, pad_present}, 32'd1);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_cs"}, {31'd0, spi_cs}, 32'd1);
    check({tag, "_clk"}, {31'd0, spi_clk}, 32'd1);
    check({tag, "_mosi"}, {31'd0, spi_mosi}, 32'd0);
    check({tag, "_key"}, {16'd0, ps2_key}, 32'd0);
    check({tag, "_axes"}, {stick_rx, stick_ry, stick_lx, stick_ly}, 32'h80808080);
    check({tag, "_id"}, {24'd0, pad_id}, 32'd0);
    check({tag, "_flags"}, {29'd0, analog_mode, pad_present, data_valid}, 32'd0);
  endtask

  task automatic run_frame(input string tag, input int start_budget);
    wait_cs(1'b0, start_budget, {tag, "_start"});
    wait_cs(1'b1, FRAME_MAX, {tag, "_end"});
    repeat (3) @(negedge clk_50m);
  endtask

  initial begin
    longint t_rise;
    logic   stayed;
    int     n;

    rst_n = 1'b0; enable = 1'b0; motor_small = 1'b0; motor_large = 8'h00; spi_miso = 1'b1;
    set_resp({9{8'hFF}});
    repeat (3) @(negedge clk_50m);
    check_reset_values("reset");

    rst_n = 1'b1; enable = 1'b1;
    set_resp({8'hFF, 8'h41, 8'h5A, 8'hFE, 8'h7F, 32'h0});
    push_exp(16'h8001, 8'h41, 1'b0, 32'h80808080);
    run_frame("dig", POLL_PERIOD + 20);
    check("dig_falls", fall_cnt, 32'd40);
    check("dig_present", {31'd0, pad_present}, 32'd1);
    check("dig_dv_count", dv_count, 32'd1);

    motor_small = 1'b1; motor_large = 8'hA5;
    set_resp({8'hFF, 8'h73, 8'h5A, 8'hFF, 8'hFF, 8'h10, 8'h20, 8'h30, 8'h40});
    push_exp(16'h0000, 8'h73, 1'b1, 32'h10203040);
    run_frame("ana", POLL_PERIOD + 20);
    check("ana_falls", fall_cnt, 32'd72);
    check("ana_dv_count", dv_count, 32'd2);
    check("mosi_b0_b3", {mosi_byte[0], mosi_byte[1], mosi_byte[2], mosi_byte[3]}, 32'h014200FF);
    check("mosi_b4", {24'd0, mosi_byte[4]}, 32'h000000A5);
    check("mosi_b5_b8", {mosi_byte[5], mosi_byte[6], mosi_byte[7], mosi_byte[8]}, 32'd0);
    check("mosi_stable", mosi_unstable, 32'd0);

    motor_small = 1'b0; motor_large = 8'h00;
    set_resp({8'hFF, 8'h41, 8'h00, 8'h00, 8'h00, 32'h0});
    run_frame("inv", POLL_PERIOD + 20);
    check("inv_falls", fall_cnt, 32'd40);
    check("inv_present", {31'd0, pad_present}, 32'd0);
    check("inv_key_held", {16'd0, ps2_key}, 32'd0);
    check("inv_id", {24'd0, pad_id}, 32'h41);
    check("inv_axes_held", {stick_rx, stick_ry, stick_lx, stick_ly}, 32'h10203040);
    check("inv_dv_count", dv_count, 32'd2);

    set_resp({9{8'hFF}});
    wait_cs(1'b0, POLL_PERIOD + 20, "nopad_start");
    wait_cs(1'b1, FRAME_MAX, "nopad_end");
    t_rise = cyc;
    repeat (3) @(negedge clk_50m);
    check("nopad_falls", fall_cnt, 32'd40);
    check("nopad_id", {24'd0, pad_id}, 32'hFF);
    check("nopad_present", {31'd0, pad_present}, 32'd0);

    set_resp({8'hFF, 8'h41, 8'h5A, 8'hFF, 8'h00, 32'h0});
    push_exp(16'hFF00, 8'h41, 1'b0, 32'h80808080);
    wait_cs(1'b0, POLL_PERIOD + 20, "poll_next_start");
    check("poll_period", 32'(cyc - t_rise), POLL_PERIOD);

    repeat (20) @(negedge clk_50m);
    enable = 1'b0;
    wait_cs(1'b1, FRAME_MAX, "en_frame_end");
    repeat (3) @(negedge clk_50m);
    check("en_falls", fall_cnt, 32'd40);
    check("en_dv_count", dv_count, 32'd3);
    stayed = 1'b1;
    repeat (2 * POLL_PERIOD) begin
      @(negedge clk_50m);
      if (spi_cs !== 1'b1) stayed = 1'b0;
    end
    check("en_hold_idle", {31'd0, stayed}, 32'd1);
    enable = 1'b1;
    wait_cs(1'b0, 2, "en_resume");

    n = 0;
    while (fall_cnt < 3 && n < 200) begin
      @(negedge clk_50m);
      n++;
    end
    check("rst_in_shift", {31'd0, spi_clk}, 32'd0);
    #3 rst_n = 1'b0;
    #1;
    check_reset_values("rst_mid");
    repeat (2) @(negedge clk_50m);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_50m);
    check("sb_drained", exp_q.size(), 32'd0);
    check("final_dv_count", dv_count, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
